// File: rtl/bcd_field_scheduler.sv
// Round-robin scheduler that shares one binary-to-BCD converter and the LCD
// character write port among four requesters, emitting three ASCII cells per grant.
module bcd_field_scheduler #(
    parameter int NREQ = 4,
    parameter int POSW = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_i,
    input  logic [8*NREQ-1:0]      value_i,
    input  logic [POSW*NREQ-1:0]   pos_i,
    input  logic                   blank_en_i,
    output logic [NREQ-1:0]        ack_o,
    output logic                   busy_o,
    output logic                   wr_valid_o,
    input  logic                   wr_ready_i,
    output logic [POSW-1:0]        wr_addr_o,
    output logic [7:0]             wr_data_o
);

    localparam int IDXW = $clog2(NREQ);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WR_H,
        WR_T,
        WR_O,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   ptr_q,   ptr_d;
    logic [IDXW-1:0]   grant_q, grant_d;
    logic [7:0]        val_q,   val_d;
    logic [POSW-1:0]   pos_q,   pos_d;
    logic              blank_q, blank_d;
    logic [1:0]        hund_q,  hund_d;
    logic [3:0]        tens_q,  tens_d;
    logic [3:0]        ones_q,  ones_d;

    logic              req_found;
    logic [IDXW-1:0]   req_idx;
    logic [9:0]        bcd;
    logic [7:0]        h_char, t_char, o_char;

    // Shift-and-add-3 conversion; the hundreds digit can never exceed 2 for
    // an 8-bit input, so only the tens and ones nibbles need correction.
    function automatic logic [9:0] bin2bcd(input logic [7:0] bin);
        logic [17:0] sh;
        sh = {10'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sh[11:8] >= 4'd5)  sh[11:8]  = sh[11:8]  + 4'd3;
            if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
            sh = sh << 1;
        end
        return sh[17:8];
    endfunction

    assign bcd = bin2bcd(val_q);

    // First requester at or after the pointer, wrapping past the last index.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            int unsigned cand;
            cand = (int'(ptr_q) + off) % NREQ;
            if (!req_found && req_i[cand]) begin
                req_found = 1'b1;
                req_idx   = IDXW'(cand);
            end
        end
    end

    // Leading-zero blanking: tens is only blank when hundreds is blank too.
    always_comb begin
        h_char = {4'h3, 2'b00, hund_q};
        t_char = {4'h3, tens_q};
        o_char = {4'h3, ones_q};
        if (blank_q && (hund_q == 2'd0)) begin
            h_char = 8'h20;
            if (tens_q == 4'd0) t_char = 8'h20;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        val_d      = val_q;
        pos_d      = pos_q;
        blank_d    = blank_q;
        hund_d     = hund_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        ack_o      = '0;
        busy_o     = 1'b1;
        wr_valid_o = 1'b0;
        wr_addr_o  = '0;
        wr_data_o  = 8'h00;

        unique case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (req_found) begin
                    grant_d = req_idx;
                    blank_d = blank_en_i;
                    for (int i = 0; i < NREQ; i++) begin
                        if (IDXW'(i) == req_idx) begin
                            val_d = value_i[8*i +: 8];
                            pos_d = pos_i[POSW*i +: POSW];
                        end
                    end
                    state_d = CONV;
                end
            end
            CONV: begin
                hund_d  = bcd[9:8];
                tens_d  = bcd[7:4];
                ones_d  = bcd[3:0];
                state_d = WR_H;
            end
            WR_H: begin
                wr_valid_o = 1'b1;
                wr_addr_o  = pos_q;
                wr_data_o  = h_char;
                if (wr_ready_i) state_d = WR_T;
            end
            WR_T: begin
                wr_valid_o = 1'b1;
                wr_addr_o  = pos_q + POSW'(1);
                wr_data_o  = t_char;
                if (wr_ready_i) state_d = WR_O;
            end
            WR_O: begin
                wr_valid_o = 1'b1;
                wr_addr_o  = pos_q + POSW'(2);
                wr_data_o  = o_char;
                if (wr_ready_i) state_d = DONE;
            end
            DONE: begin
                ack_o[grant_q] = 1'b1;
                ptr_d          = grant_q + IDXW'(1);
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            val_q   <= '0;
            pos_q   <= '0;
            blank_q <= 1'b0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            val_q   <= val_d;
            pos_q   <= pos_d;
            blank_q <= blank_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

endmodule

// File: tb/tb_bcd_field_scheduler.sv
// Scoreboard bench for bcd_field_scheduler: stimulus queues expected writes and
// acks, an independent monitor compares them whenever the DUT presents one.
module tb_bcd_field_scheduler;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_i;
    logic [31:0] value_i;
    logic [19:0] pos_i;
    logic        blank_en_i;
    logic [3:0]  ack_o;
    logic        busy_o;
    logic        wr_valid_o;
    logic        wr_ready_i;
    logic [4:0]  wr_addr_o;
    logic [7:0]  wr_data_o;

    int checks = 0;
    int errors = 0;
    wr_t        wq[$];
    logic [3:0] aq[$];

    bcd_field_scheduler #(.NREQ(4), .POSW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .value_i    (value_i),
        .pos_i      (pos_i),
        .blank_en_i (blank_en_i),
        .ack_o      (ack_o),
        .busy_o     (busy_o),
        .wr_valid_o (wr_valid_o),
        .wr_ready_i (wr_ready_i),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push3(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                         input logic [3:0] ack);
        wq.push_back({a0, c0});
        wq.push_back({a1, c1});
        wq.push_back({a2, c2});
        aq.push_back(ack);
    endtask

    task automatic chk_outputs_zero(input string tag);
        check({tag, "_ack"},   32'(ack_o),      32'd0);
        check({tag, "_busy"},  32'(busy_o),     32'd0);
        check({tag, "_valid"}, 32'(wr_valid_o), 32'd0);
        check({tag, "_addr"},  32'(wr_addr_o),  32'd0);
        check({tag, "_data"},  32'(wr_data_o),  32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called at the start of an IDLE cycle (cycle 0); returns one cycle after ACK.
    task automatic run_one(input logic [3:0] req, input int st, input int sl, input int exp_ack);
        int got;
        got = -1;
        req_i = req;
        for (int k = 0; k < 40 && got < 0; k++) begin
            wr_ready_i = !(k >= st && k < st + sl);
            @(negedge clk);
            check("busy",     32'(busy_o),     32'(k >= 1 && k <= exp_ack));
            check("wr_valid", 32'(wr_valid_o), 32'(k >= 2 && k < exp_ack));
            if (ack_o != 4'd0) got = k;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("ack_cycle", 32'(got), 32'(exp_ack));
        @(posedge clk);
        #1;
        req_i      = 4'd0;
        wr_ready_i = 1'b1;
    endtask

    initial begin : monitor
        logic       stall_seen;
        logic [4:0] stall_addr;
        logic [7:0] stall_data;
        wr_t        e;
        logic [3:0] ea;
        stall_seen = 1'b0;
        stall_addr = '0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_seen = 1'b0;
            end else begin
                if (stall_seen && wr_valid_o) begin
                    check("stall_addr", 32'(wr_addr_o), 32'(stall_addr));
                    check("stall_data", 32'(wr_data_o), 32'(stall_data));
                end
                if (wr_valid_o && wr_ready_i) begin
                    if (wq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_write: got addr %0d data %0h expected none", wr_addr_o, wr_data_o);
                    end else begin
                        e = wq.pop_front();
                        check("wr_addr", 32'(wr_addr_o), 32'(e.addr));
                        check("wr_data", 32'(wr_data_o), 32'(e.data));
                    end
                end
                stall_seen = wr_valid_o && !wr_ready_i;
                stall_addr = wr_addr_o;
                stall_data = wr_data_o;
                if (ack_o != 4'd0) begin
                    if (aq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_ack: got %b expected none", ack_o);
                    end else begin
                        ea = aq.pop_front();
                        check("ack", 32'(ack_o), 32'(ea));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0]  t2_val [4];
        logic [23:0] t2_exp [4];
        int n, last, got;

        t2_val = '{8'h07, 8'h00, 8'h64, 8'h0A};
        t2_exp = '{24'h202037, 24'h202030, 24'h313030, 24'h203130};

        rst_n      = 1'b0;
        req_i      = 4'd0;
        value_i    = 32'd0;
        pos_i      = 20'd0;
        blank_en_i = 1'b0;
        wr_ready_i = 1'b1;
        #2 chk_outputs_zero("por");
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request, full value, no blanking.
        value_i[7:0] = 8'hFF;
        pos_i[4:0]   = 5'd0;
        blank_en_i   = 1'b0;
        push3(5'd0, 5'd1, 5'd2, 8'h32, 8'h35, 8'h35, 4'b0001);
        run_one(4'b0001, 0, 0, 5);

        // Leading-zero blanking through requester 1 at position 10.
        value_i[15:8] = 8'h00;
        pos_i[9:5]    = 5'd10;
        blank_en_i    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            value_i[15:8] = t2_val[i];
            push3(5'd10, 5'd11, 5'd12, t2_exp[i][23:16], t2_exp[i][15:8], t2_exp[i][7:0], 4'b0010);
            run_one(4'b0010, 0, 0, 5);
        end

        // Fairness with all four requesting continuously from a reset pointer.
        do_reset();
        value_i    = {8'h05, 8'hC8, 8'h99, 8'h2A};
        pos_i      = {5'd20, 5'd16, 5'd3, 5'd0};
        blank_en_i = 1'b0;
        push3(5'd0,  5'd1,  5'd2,  8'h30, 8'h34, 8'h32, 4'b0001);
        push3(5'd3,  5'd4,  5'd5,  8'h31, 8'h35, 8'h33, 4'b0010);
        push3(5'd16, 5'd17, 5'd18, 8'h32, 8'h30, 8'h30, 4'b0100);
        push3(5'd20, 5'd21, 5'd22, 8'h30, 8'h30, 8'h35, 4'b1000);
        push3(5'd0,  5'd1,  5'd2,  8'h30, 8'h34, 8'h32, 4'b0001);
        push3(5'd3,  5'd4,  5'd5,  8'h31, 8'h35, 8'h33, 4'b0010);
        req_i = 4'b1111;
        n = 0;
        last = 0;
        for (int k = 0; k < 80 && n < 6; k++) begin
            @(negedge clk);
            if (ack_o != 4'd0) begin
                if (n > 0) check("grant_period", 32'(k - last), 32'd6);
                last = k;
                n++;
            end
        end
        check("fair_ack_count", 32'(n), 32'd6);
        @(posedge clk);
        #1 req_i = 4'd0;

        // Backpressure: three not-ready cycles while the tens digit is offered.
        value_i[31:24] = 8'h55;
        pos_i[19:15]   = 5'd7;
        blank_en_i     = 1'b1;
        push3(5'd7, 5'd8, 5'd9, 8'h20, 8'h38, 8'h35, 4'b1000);
        run_one(4'b1000, 3, 3, 8);

        // Address wrap past the last cell.
        value_i[23:16] = 8'd123;
        pos_i[14:10]   = 5'd31;
        blank_en_i     = 1'b0;
        push3(5'd31, 5'd0, 5'd1, 8'h31, 8'h32, 8'h33, 4'b0100);
        run_one(4'b0100, 0, 0, 5);

        // Reset in the middle of the tens write; only the hundreds write lands.
        value_i[23:16] = 8'hED;
        pos_i[14:10]   = 5'd12;
        blank_en_i     = 1'b0;
        wq.push_back({5'd12, 8'h32});
        req_i = 4'b0100;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        wr_ready_i = 1'b0;
        check("pre_reset_valid", 32'(wr_valid_o), 32'd1);
        check("pre_reset_addr",  32'(wr_addr_o),  32'd13);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("midop_reset");
        push3(5'd12, 5'd13, 5'd14, 8'h32, 8'h33, 8'h37, 4'b0100);
        @(posedge clk);
        #3 rst_n = 1'b1;
        wr_ready_i = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            @(negedge clk);
            if (ack_o != 4'd0) got = 1;
        end
        check("regrant_ack_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1 req_i = 4'd0;

        // Pointer restarts at 0 after reset: with 1010 requester 1 wins, not 3.
        do_reset();
        value_i[15:8] = 8'h09;
        pos_i[9:5]    = 5'd5;
        blank_en_i    = 1'b1;
        push3(5'd5, 5'd6, 5'd7, 8'h20, 8'h20, 8'h39, 4'b0010);
        run_one(4'b1010, 0, 0, 5);

        repeat (3) @(posedge clk);
        #1;
        check("writes_drained", 32'(wq.size()), 32'd0);
        check("acks_drained",   32'(aq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
